// File: rtl/resp_sig_collector.sv
// Response signature collector: folds each accepted response word to 32 bits and
// compacts the stream into a CRC-32 style signature, then compares it to a golden value.
module resp_sig_collector #(
  parameter int OUT_W = 159,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             resp_valid,
  input  logic [OUT_W-1:0] resp_data,
  input  logic [31:0]      expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      signature,
  output logic [CNT_W-1:0] sample_count
);

  localparam int NWORDS = (OUT_W + 31) / 32;
  localparam int PAD_W  = NWORDS * 32;
  localparam logic [31:0]      SIG_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY = 32'h04C1_1DB7;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_sig, w_sig_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_len, w_len_nxt;
  logic             r_busy, r_done;
  logic [CNT_W-1:0] w_cnt_inc;

  // Zero-extend to a whole number of 32-bit words and XOR the words together.
  function automatic logic [31:0] fold_word(input logic [OUT_W-1:0] d);
    logic [PAD_W-1:0] padded;
    logic [31:0]      acc;
    padded = {PAD_W{1'b0}};
    padded[OUT_W-1:0] = d;
    acc = 32'h0000_0000;
    for (int i = 0; i < NWORDS; i++) begin
      acc = acc ^ padded[i*32 +: 32];
    end
    return acc;
  endfunction

  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] fold);
    return {sig[30:0], 1'b0} ^ (sig[31] ? CRC_POLY : 32'h0000_0000) ^ fold;
  endfunction

  assign w_cnt_inc = r_cnt + CNT_ONE;

  // Next-state, signature and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_sig_nxt   = r_sig;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_sig_nxt = SIG_SEED;
          w_cnt_nxt = CNT_ZERO;
          w_len_nxt = num_cycles;
          if (num_cycles != CNT_ZERO) begin
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CAPTURE: begin
        if (resp_valid) begin
          w_sig_nxt = sig_step(r_sig, fold_word(resp_data));
          w_cnt_nxt = w_cnt_inc;
          // The length is never zero here, so the count stops at it and never wraps.
          if (w_cnt_inc == r_len) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sig_nxt   = SIG_SEED;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sig   <= SIG_SEED;
      r_cnt   <= CNT_ZERO;
      r_len   <= CNT_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_busy  <= (w_state_nxt == ST_CAPTURE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign signature    = r_sig;
  assign sample_count = r_cnt;
  assign pass         = r_done & (r_sig == expected_sig);

endmodule

// File: tb/tb_resp_sig_collector.sv
// Self-checking bench for resp_sig_collector: directed cases with literal expectations
// plus randomized runs compared every cycle against a behavioural model.
module tb_resp_sig_collector;

  localparam int OUT_W = 159;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_cycles = '0;
  logic             resp_valid = 1'b0;
  logic [OUT_W-1:0] resp_data = '0;
  logic [31:0]      expected_sig = 32'h0;
  logic             busy, done, pass;
  logic [31:0]      signature;
  logic [CNT_W-1:0] sample_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  resp_sig_collector #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
    .resp_valid(resp_valid), .resp_data(resp_data), .expected_sig(expected_sig),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference fold: bit i of the response lands on bit (i mod 32) of the folded word.
  function automatic logic [31:0] m_fold(input logic [OUT_W-1:0] d);
    logic [31:0] f = 32'h0;
    for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ d[i];
    return f;
  endfunction

  // Reference step as polynomial arithmetic: multiply by x, reduce mod the CRC-32 polynomial.
  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [31:0] f);
    logic [32:0] t = {s, 1'b0};
    if (t[32]) t = t ^ 33'h1_04C1_1DB7;
    return t[31:0] ^ f;
  endfunction

  // Behavioural model: phase 0 idle, 1 collecting, 2 finished.
  int               m_phase = 0;
  int               m_len = 0;
  logic [31:0]      m_sig = 32'hFFFF_FFFF;
  int               m_cnt = 0;
  logic [OUT_W-1:0] m_q[$];

  function automatic logic [31:0] sig_of_queue();
    logic [31:0] s = 32'hFFFF_FFFF;
    foreach (m_q[i]) s = m_step(s, m_fold(m_q[i]));
    return s;
  endfunction

  // Model update on each rising edge from the inputs presented during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_sig <= 32'hFFFF_FFFF; m_cnt <= 0; m_q.delete();
    end else if (m_phase != 1 && start) begin
      m_sig <= 32'hFFFF_FFFF; m_cnt <= 0; m_len <= int'(num_cycles); m_q.delete();
      m_phase <= (num_cycles == 0) ? 2 : 1;
    end else if (m_phase == 1 && resp_valid) begin
      m_sig <= m_step(m_sig, m_fold(resp_data));
      m_cnt <= m_cnt + 1;
      m_q.push_back(resp_data);
      if (m_cnt + 1 == m_len) m_phase <= 2;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(m_phase == 1));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("pass", 64'(pass), 64'((m_phase == 2) && (m_sig == expected_sig)));
      chk("signature", 64'(signature), 64'(m_sig));
      chk("sample_count", 64'(sample_count), 64'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [OUT_W-1:0] rand_data();
    logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[OUT_W-1:0];
  endfunction

  task automatic start_run(input int n);
    start = 1'b1; num_cycles = CNT_W'(n);
    cyc();
    start = 1'b0;
  endtask

  task automatic feed(input logic [OUT_W-1:0] d);
    resp_valid = 1'b1; resp_data = d;
    cyc();
    resp_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin cyc(); k++; end
    chk(name, 64'(done), 64'd1);
  endtask

  logic [31:0] lcg;
  logic [159:0] wide;
  int n, k;

  initial begin
    cyc();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_sig", 64'(signature), 64'hFFFF_FFFF);
    chk("reset_cnt", 64'(sample_count), 64'd0);
    chk("reset_flags", 64'({busy, done, pass}), 64'd0);
    cyc();
    rst = 1'b0;

    // Single zero sample
    start_run(1);
    feed('0);
    @(negedge clk);
    chk("one_zero_sig", 64'(signature), 64'hFB3E_E249);
    chk("one_zero_done", 64'(done), 64'd1);
    chk("one_zero_cnt", 64'(sample_count), 64'd1);

    // Single sample with bit 0 set, pass both ways
    cyc();
    expected_sig = 32'hFB3E_E248;
    start_run(1);
    feed({{(OUT_W-1){1'b0}}, 1'b1});
    @(negedge clk);
    chk("bit0_sig", 64'(signature), 64'hFB3E_E248);
    chk("bit0_pass", 64'(pass), 64'd1);
    expected_sig = 32'hFB3E_E249;
    #1;
    chk("bit0_nopass", 64'(pass), 64'd0);

    // Zero-length run from DONE
    cyc();
    start_run(0);
    @(negedge clk);
    chk("zero_len_done", 64'(done), 64'd1);
    chk("zero_len_sig", 64'(signature), 64'hFFFF_FFFF);
    chk("zero_len_busy", 64'(busy), 64'd0);

    // Gapped valid pattern with start pulses ignored during capture
    cyc();
    start_run(4);
    for (int i = 0; i < 6; i++) begin
      resp_valid = (i == 1 || i == 3) ? 1'b0 : 1'b1;
      resp_data = rand_data();
      start = (i == 2); num_cycles = CNT_W'(9);
      cyc();
    end
    resp_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("gap_cnt", 64'(sample_count), 64'd4);
    chk("gap_done", 64'(done), 64'd1);
    chk("gap_queue_sig", 64'(signature), 64'(sig_of_queue()));

    // Reset after 2 of 5 samples, then a fresh run
    cyc();
    start_run(5);
    feed(rand_data());
    feed(rand_data());
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_sig", 64'(signature), 64'hFFFF_FFFF);
    chk("abort_cnt", 64'(sample_count), 64'd0);
    chk("abort_flags", 64'({busy, done}), 64'd0);
    cyc();
    start_run(3);
    for (int i = 0; i < 3; i++) feed(rand_data());
    @(negedge clk);
    chk("fresh_cnt", 64'(sample_count), 64'd3);
    chk("fresh_sig", 64'(signature), 64'(sig_of_queue()));

    // 100-sample LCG stream started straight from DONE
    cyc();
    lcg = 32'h1234_5678;
    start_run(100);
    k = 0;
    while (!done && k < 400) begin
      resp_valid = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < 5; w++) begin
        lcg = lcg * 32'd1103515245 + 32'd12345;
        wide[w*32 +: 32] = lcg;
      end
      resp_data = wide[OUT_W-1:0];
      cyc();
      k++;
    end
    resp_valid = 1'b0;
    chk("lcg_finished", 64'(done), 64'd1);
    @(negedge clk);
    chk("lcg_cnt", 64'(sample_count), 64'd100);
    chk("lcg_sig", 64'(signature), 64'(sig_of_queue()));

    // Randomized runs with gaps, ignored starts and occasional resets
    for (int r = 0; r < 12; r++) begin
      cyc();
      n = $urandom_range(0, 12);
      start_run(n);
      k = 0;
      while (m_phase == 1 && k < 80) begin
        resp_valid = ($urandom_range(0, 2) != 0);
        resp_data = rand_data();
        start = ($urandom_range(0, 4) == 0);
        num_cycles = CNT_W'($urandom_range(0, 7));
        rst = ($urandom_range(0, 59) == 0);
        cyc();
        k++;
      end
      resp_valid = 1'b0; start = 1'b0; rst = 1'b0;
      chk("rand_terminated", 64'(m_phase != 1), 64'd1);
      if (m_phase == 2) begin
        expected_sig = ($urandom_range(0, 1) != 0) ? m_sig : $urandom;
        @(negedge clk);
        chk("rand_queue_sig", 64'(signature), 64'(sig_of_queue()));
      end
    end

    cyc();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
